// File: rtl/tinycpu_pkg.sv
// Shared definitions for the tiny CPU front end: data width, the EBREAK
// encoding and the fetch state machine encoding.
package tinycpu_pkg;

    localparam int XLEN = 32;

    // EBREAK encoding; a fetch of this word stops the front end when halting is built in.
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its address and the
// valid flag. The parent decides when to load, flush or hold.
module if_id_reg
    import tinycpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Load a new instruction, drop the valid flag on flush, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            // Only the valid flag matters after a flush; the payload is stale but harmless.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and the FETCH/HALT state machine and
// drives an asynchronous-read instruction ROM. The fetched word goes to the
// decode stage through if_id_reg with a valid/ready handshake.
// Optional feature: define FETCH_HALT_EN to stop fetching after an EBREAK.
module instr_fetch
    import tinycpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic              halted
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    fetch_state_t    state_q;
    logic            out_free;
    logic            do_fetch;
    logic            do_flush;

    // The output register can take a new word when empty or being drained this cycle.
    assign out_free = !id_valid || id_ready;
    assign do_fetch = out_free && fetch_en && (state_q == FETCH) && !redirect_valid;
    // A redirect flushes unconditionally; an idle-but-free register simply empties.
    assign do_flush = redirect_valid || (out_free && !do_fetch);

    // ROM index wraps naturally because only the word-address bits are used.
    assign imem_addr = pc_q[ADDR_W+1:2];

    // Next PC: redirect wins over sequential advance; pc+4 wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (do_fetch) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC register; reset overrides any redirect or handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_HALT_EN
    // FETCH/HALT machine: a fetched EBREAK parks the stage until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else if (do_fetch && (imem_data == INSTR_EBREAK)) begin
            state_q <= HALT;
        end
    end

    assign halted = (state_q == HALT);
`else
    // Without the halt feature the stage never leaves FETCH.
    assign state_q = FETCH;
    assign halted  = 1'b0;
`endif

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (do_fetch),
        .flush_i (do_flush),
        .instr_i (imem_data),
        .pc_i    (pc_q),
        .valid_o (id_valid),
        .instr_o (id_instr),
        .pc_o    (id_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;

    logic [31:0] rom [64];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: the architectural view of the stage.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic        m_halt;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Word index the ROM sees for a given byte address.
    function automatic logic [31:0] rom_index(input logic [31:0] addr);
        return (addr >> 2) % 64;
    endfunction

    // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
    task automatic step(input logic rst, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        logic free;
        reset          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        free = !m_valid || rdy;
        if (rst) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_halt = 1'b0;
        end else if (rv) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_valid = 1'b0;
        end else if (free && fe && !m_halt) begin
            m_instr = rom[rom_index(m_pc)];
            m_idpc  = m_pc;
            m_valid = 1'b1;
            if (HALT_EN && m_instr == EBREAK) m_halt = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("id_valid",  {31'd0, id_valid}, {31'd0, m_valid});
        check("id_instr",  id_instr, m_instr);
        check("id_pc",     id_pc, m_idpc);
        check("halted",    {31'd0, halted}, {31'd0, m_halt});
        check("imem_addr", {26'd0, imem_addr}, rom_index(m_pc));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; id_ready = 1'b1;
        m_pc = '0; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_halt = 1'b0;

        // Reset state, with a redirect asserted to prove reset overrides it.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_addr",  {26'd0, imem_addr}, rom_index(RESET_PC));

        // Streaming: one instruction per cycle from RESET_PC.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check("stream_pc",    id_pc, 32'(k * 4));
            check("stream_instr", id_instr, 32'h1000_0000 + 32'(k));
        end

        // Backpressure: hold id_pc=8 for three cycles.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            check("stall_pc",    id_pc, 32'd8);
            check("stall_instr", id_instr, 32'h1000_0002);
            check("stall_addr",  {26'd0, imem_addr}, 32'd3);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_release_pc", id_pc, 32'd12);

        // Redirect during a stall, unaligned target.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0022, 1'b0);
        check("redir_flush", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_pc",    id_pc, 32'h0000_0020);
        check("redir_instr", id_instr, 32'h1000_0008);

        // ROM index wrap at 64 words.
        step(1'b0, 1'b1, 1'b1, 32'h0000_00FC, 1'b1);
        check("wrap_addr63", {26'd0, imem_addr}, 32'd63);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_addr0", {26'd0, imem_addr}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_pc",    id_pc, 32'h0000_0100);
        check("wrap_instr", id_instr, 32'h1000_0000);

        // 32-bit PC wrap.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("pc32_top", id_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("pc32_wrap", id_pc, 32'h0000_0000);

        // Reset in the middle of a stall discards the held word.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_stall_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_stall_pc", id_pc, RESET_PC);

        // EBREAK at word 3: halts when the feature is built in, ordinary otherwise.
        rom[3] = EBREAK;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("ebreak_pc",    id_pc, 32'd12);
        check("ebreak_instr", id_instr, EBREAK);
        check("ebreak_halt",  {31'd0, halted}, {31'd0, HALT_EN});
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("ebreak_after_valid", {31'd0, id_valid}, {31'd0, !HALT_EN});
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        check("ebreak_redir_halt", {31'd0, halted}, {31'd0, HALT_EN});
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("ebreak_redir_valid", {31'd0, id_valid}, {31'd0, !HALT_EN});
        do_reset();
        check("ebreak_rst_halt", {31'd0, halted}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("ebreak_resume_pc", id_pc, RESET_PC);

        // Random traffic against the model.
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(7) != 0),
                 ($urandom_range(7) == 0),
                 $urandom,
                 ($urandom_range(3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the instruction-ROM word-address width (64 words).
REQ-003 Port clk, input, 1 bit: the single CPU clock (Clk_CPU domain); all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port fetch_en, input, 1 bit: when 1, the block may issue a new fetch.
REQ-006 Port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-007 Port redirect_pc, input, 32 bits: redirect target address.
REQ-008 Port imem_addr, output, ADDR_W bits: word address to the asynchronous-read ROM.
REQ-009 Port imem_data, input, 32 bits: ROM read data, combinational from imem_addr.
REQ-010 Port id_valid, output, 1 bit: id_instr and id_pc hold a valid fetched instruction.
REQ-011 Port id_ready, input, 1 bit: the decode stage accepts the instruction this cycle.
REQ-012 Port id_instr, output, 32 bits: fetched instruction.
REQ-013 Port id_pc, output, 32 bits: address of id_instr.
REQ-014 Port halted, output, 1 bit: fetch has stopped on EBREAK.

Function
REQ-015 The block SHALL drive imem_addr = pc[ADDR_W+1:2] combinationally, so the ROM index wraps modulo 2^ADDR_W words.
REQ-016 The output register SHALL be free when id_valid=0, or when id_valid=1 and id_ready=1.
REQ-017 A fetch SHALL occur when the output register is free, fetch_en=1, state=FETCH and redirect_valid=0, with these edge updates: id_instr<=imem_data, id_pc<=pc, id_valid<=1, pc<=pc+4.
REQ-018 Fetch latency SHALL be one cycle from PC to id_valid, giving one instruction per cycle when id_ready stays 1.
REQ-019 When the output register is free and no fetch occurs, the block SHALL set id_valid<=0.
REQ-020 When id_valid=1 and id_ready=0, the block SHALL hold id_valid, id_instr, id_pc and pc unchanged.
REQ-021 On redirect_valid=1, the block SHALL set pc<=redirect_pc & ~32'h3 and id_valid<=0 in that cycle, regardless of id_ready, stall or fetch_en.
REQ-022 After a redirect, the first fetch SHALL be at the target on the following cycle.
REQ-023 Redirect SHALL take priority over fetch, hold and halt detection.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 The state machine SHALL have two states: FETCH and HALT.
REQ-026 Without the halt feature, the state SHALL remain FETCH permanently.

Reset
REQ-027 On reset=1 at a rising edge, the block SHALL set pc<=RESET_PC, id_valid<=0, id_instr<=0, id_pc<=0, state<=FETCH and halted<=0, overriding redirect and any in-flight handshake.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-029 With macro FETCH_HALT_EN defined, when a fetch loads imem_data == 32'h0010_0073 (EBREAK), the block SHALL move to HALT and assert halted on the next cycle.
REQ-030 With FETCH_HALT_EN defined, the EBREAK instruction SHALL itself be delivered normally.
REQ-031 With FETCH_HALT_EN defined, in HALT no fetch SHALL occur, and only reset SHALL leave HALT.
REQ-032 With FETCH_HALT_EN defined, a redirect in HALT SHALL update pc and flush but SHALL NOT resume fetching.
REQ-033 Without FETCH_HALT_EN, halted SHALL be tied to 0 and EBREAK SHALL be fetched as an ordinary instruction.

Structure
REQ-034 Shared package tinycpu_pkg SHALL hold XLEN=32, the INSTR_EBREAK constant 32'h0010_0073, and the fetch_state_t enum {FETCH, HALT}.
REQ-035 The block SHALL contain one sub-module, if_id_reg, holding id_valid, id_instr and id_pc with the load, hold and flush controls; PC and FSM logic SHALL stay in instr_fetch.

Verification
REQ-036 Streaming: ROM[i]=32'h1000_0000+i, id_ready=1, fetch_en=1 after reset -> id_pc = 0,4,8,... on consecutive cycles, with id_instr = 32'h1000_0000, 32'h1000_0001, ...
REQ-037 Backpressure: id_ready=0 for 3 cycles while id_pc=8 -> id_pc=8 and its instruction are held for 3 cycles, pc is unchanged, and id_pc=12 appears the cycle after id_ready returns to 1.
REQ-038 Redirect during stall: id_valid=1, id_ready=0, redirect_pc=32'h0000_0022 -> id_valid=0 next cycle, then id_pc=32'h0000_0020.
REQ-039 Wrap: redirect to 32'h0000_00FC with ADDR_W=6 -> imem_addr=63, then imem_addr=0 with id_pc=32'h0000_0100.
REQ-040 Halt (FETCH_HALT_EN): ROM[3]=32'h0010_0073 -> id_pc=12 is delivered, halted=1 afterwards, and id_valid drops after the handshake; a redirect leaves halted=1; reset clears it.
REQ-041 Reset mid-stall: id_valid=1, id_ready=0, reset=1 for one cycle -> id_valid=0 and the first fetch is at RESET_PC.
